// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and load/store.
// Each transaction is latched, driven on the bus until mem_ack, then acked one cycle later.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, FETCH, DATA, RESP, REJECT} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [31:0] a_addr, a_wdata, rdata_r;
  logic [1:0]  a_size;
  logic [3:0]  a_be;
  logic        a_we, a_fetch;

  logic        d_req, grant_d, grant_if, bad;
  logic [3:0]  lane_be;
  logic [31:0] lane_wd, rd_lane;

  assign d_req    = d_read | d_write;
  // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
  assign grant_d  = d_req && !(if_req && cnt >= LIM);
  assign grant_if = if_req && !grant_d;
  assign bad      = (d_size == 2'b11) ||
                    (d_size == 2'b01 && d_addr[0]) ||
                    (d_size == 2'b10 && d_addr[1:0] != 2'b00);

  always_comb begin
    lane_be = 4'b1111;
    lane_wd = d_wdata;
    case (d_size)
      2'b00: begin
        lane_be = 4'b0001 << d_addr[1:0];
        lane_wd = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        lane_be = 4'b0011 << d_addr[1:0];
        lane_wd = {2{d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_lane = mem_rdata;
    case (a_size)
      2'b00:   rd_lane = {24'h0, 8'(mem_rdata >> {a_addr[1:0], 3'b000})};
      2'b01:   rd_lane = {16'h0, 16'(mem_rdata >> {a_addr[1], 4'b0000})};
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_d)       state_nx = bad ? REJECT : DATA;
        else if (grant_if) state_nx = FETCH;
      end
      FETCH, DATA: if (mem_ack) state_nx = RESP;
      RESP, REJECT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      a_addr  <= '0;
      a_wdata <= '0;
      a_size  <= '0;
      a_be    <= '0;
      a_we    <= 1'b0;
      a_fetch <= 1'b0;
      rdata_r <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        if (grant_if || !if_req)        cnt <= '0;
        else if (grant_d && cnt < LIM)  cnt <= cnt + 1'b1;
        if (grant_d || grant_if) begin
          a_addr  <= grant_d ? d_addr : if_addr;
          a_we    <= grant_d & d_write;
          a_fetch <= !grant_d;
          a_size  <= grant_d ? d_size : 2'b10;
          a_be    <= grant_d ? lane_be : 4'b1111;
          a_wdata <= lane_wd;
        end
      end
      if ((state == FETCH || state == DATA) && mem_ack) rdata_r <= rd_lane;
    end
  end

  // Bus and ack outputs decode straight from state so reset clears them at once.
  assign mem_req    = (state == FETCH) || (state == DATA);
  assign mem_we     = a_we;
  assign mem_addr   = {a_addr[31:2], 2'b00};
  assign mem_wdata  = a_wdata;
  assign mem_be     = a_be;
  assign if_ack     = (state == RESP) && a_fetch;
  assign d_ack      = ((state == RESP) && !a_fetch) || (state == REJECT);
  assign d_misalign = (state == REJECT);
  assign if_rdata   = if_ack ? rdata_r : 32'h0;
  assign d_rdata    = ((state == RESP) && !a_fetch) ? rdata_r : 32'h0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench: expected bus transactions and acks are queued at stimulus time
// and compared by a memory model and an ack monitor as the DUT produces them.
module tb_mem_port_arbiter;
  logic        clk = 0, reset = 1;
  logic        if_req = 0, d_read = 0, d_write = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [1:0]  d_size = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, d_misalign, mem_req, mem_we;
  logic [3:0]  mem_be;

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_rdata(d_rdata), .d_ack(d_ack), .d_misalign(d_misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        fetch, chk_rd, mis;
    logic [31:0] rd;
    int          ref_c;
  } exp_t;
  typedef struct {
    logic        we, chk_wd;
    logic [31:0] addr, wd;
    logic [3:0]  be;
  } bus_t;

  exp_t ack_q[$];
  bus_t bus_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, mack_cyc = 0, mdelay = 1;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00)
      case (off)
        2'd0: r = {24'h0, w[7:0]};
        2'd1: r = {24'h0, w[15:8]};
        2'd2: r = {24'h0, w[23:16]};
        default: r = {24'h0, w[31:24]};
      endcase
    else if (sz == 2'b01)
      r = off[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
    return r;
  endfunction

  // Memory model: checks each new bus request against the queue and answers after mdelay cycles.
  bus_t cur;
  bit   busy = 0;
  int   cd = 0;
  always @(negedge clk) begin
    if (reset) begin
      busy = 0; mem_ack = 0;
    end else if (mem_ack) begin
      mem_ack = 0; busy = 0;
      chk("req_drop", {31'h0, mem_req}, 0);
    end else if (mem_req) begin
      if (!busy) begin
        busy = 1; cd = mdelay;
        cur = '{we: mem_we, chk_wd: 1'b0, addr: mem_addr, wd: mem_wdata, be: mem_be};
        if (bus_q.size() == 0) chk("unexp_req", 1, 0);
        else begin
          bus_t b;
          b = bus_q.pop_front();
          chk("mem_we", {31'h0, mem_we}, {31'h0, b.we});
          chk("mem_addr", mem_addr, b.addr);
          chk("mem_be", {28'h0, mem_be}, {28'h0, b.be});
          if (b.chk_wd) chk("mem_wdata", mem_wdata, b.wd);
        end
      end else begin
        chk("bus_stable", {31'h0, (mem_we == cur.we && mem_addr == cur.addr &&
                                   mem_wdata == cur.wd && mem_be == cur.be)}, 1);
        cd--;
      end
      if (cd == 0) begin
        mem_ack = 1; mem_rdata = memf(mem_addr); mack_cyc = cyc;
      end
    end
  end

  // Ack monitor: every ack must match the next queued expectation in order.
  always @(negedge clk) begin
    if (!reset && (if_ack || d_ack)) begin
      chk("one_ack", {31'h0, if_ack & d_ack}, 0);
      if (ack_q.size() == 0) chk("unexp_ack", 1, 0);
      else begin
        exp_t e;
        e = ack_q.pop_front();
        chk("ack_kind", {31'h0, if_ack}, {31'h0, e.fetch});
        chk("misalign", {31'h0, d_misalign}, {31'h0, e.mis});
        if (e.chk_rd) chk(e.fetch ? "if_rdata" : "d_rdata", e.fetch ? if_rdata : d_rdata, e.rd);
        chk("ack_lat", cyc, e.mis ? e.ref_c + 1 : mack_cyc + 1);
      end
    end
  end

  task automatic req_data(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic [3:0] ebe, input logic [31:0] ewd);
    d_read = !we; d_write = we; d_addr = addr; d_wdata = wd; d_size = sz;
    bus_q.push_back('{we: we, chk_wd: we, addr: {addr[31:2], 2'b00}, wd: ewd, be: ebe});
    ack_q.push_back('{fetch: 0, chk_rd: !we, mis: 0,
                      rd: extract(memf({addr[31:2], 2'b00}), addr[1:0], sz), ref_c: 0});
  endtask

  task automatic req_fetch(input logic [31:0] addr);
    if_req = 1; if_addr = addr;
    bus_q.push_back('{we: 0, chk_wd: 0, addr: {addr[31:2], 2'b00}, wd: 0, be: 4'hF});
    ack_q.push_back('{fetch: 1, chk_rd: 1, mis: 0, rd: memf({addr[31:2], 2'b00}), ref_c: 0});
  endtask

  task automatic req_reject(input logic [31:0] addr, input logic [1:0] sz);
    d_read = 1; d_write = 0; d_addr = addr; d_size = sz;
    ack_q.push_back('{fetch: 0, chk_rd: 1, mis: 1, rd: 0, ref_c: cyc});
  endtask

  // Waits for n acks; requesters drop on their own ack unless hold keeps them up to the end.
  task automatic wait_acks(input int n, input bit hold);
    int got = 0;
    for (int t = 0; t < 300 && got < n; t++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        got++;
        if (!hold) begin
          if (if_ack) if_req = 0;
          if (d_ack) begin d_read = 0; d_write = 0; end
        end
      end
    end
    if (hold) begin if_req = 0; d_read = 0; d_write = 0; end
    if (got < n) chk("ack_timeout", got, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 0);
    chk("rst_acks", {30'h0, if_ack, d_ack}, 0);
    chk("rst_mis", {31'h0, d_misalign}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", {28'h0, mem_be}, 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);
    reset = 0;
    @(negedge clk);

    mdelay = 2;
    req_fetch(32'h100);
    wait_acks(1, 0);

    mdelay = 1;
    @(negedge clk);
    req_data(0, 32'h200, 0, 2'b10, 4'hF, 0);
    req_fetch(32'h104);
    wait_acks(2, 0);

    @(negedge clk);
    req_data(1, 32'h203, 32'hAB, 2'b00, 4'b1000, 32'hABABABAB);
    wait_acks(1, 0);
    mdelay = 3;
    req_data(0, 32'h206, 0, 2'b00, 4'b0100, 0);
    wait_acks(1, 0);
    req_data(0, 32'h212, 0, 2'b01, 4'b1100, 0);
    wait_acks(1, 0);
    mdelay = 1;
    req_data(1, 32'h222, 32'h5678_1234, 2'b01, 4'b1100, 32'h12341234);
    wait_acks(1, 0);
    req_data(1, 32'h230, 32'hCAFEF00D, 2'b10, 4'hF, 32'hCAFEF00D);
    wait_acks(1, 0);

    @(negedge clk);
    req_reject(32'h201, 2'b01);
    wait_acks(1, 0);
    @(negedge clk);
    req_reject(32'h206, 2'b10);
    wait_acks(1, 0);
    @(negedge clk);
    req_reject(32'h200, 2'b11);
    wait_acks(1, 0);

    // Fetch held against a continuous load stream: four loads, one fetch, then loads again.
    @(negedge clk);
    if_req = 1; if_addr = 32'h108;
    for (int i = 0; i < 4; i++) req_data(0, 32'h240, 0, 2'b10, 4'hF, 0);
    req_fetch(32'h108);
    req_data(0, 32'h240, 0, 2'b10, 4'hF, 0);
    wait_acks(6, 1);

    // Reset in the middle of a bus transaction.
    @(negedge clk);
    mdelay = 20;
    req_fetch(32'h300);
    for (int t = 0; t < 10 && !mem_req; t++) @(negedge clk);
    chk("abort_setup", {31'h0, mem_req}, 1);
    #2 reset = 1;
    #1 chk("abort_req", {31'h0, mem_req}, 0);
    chk("abort_ack", {30'h0, if_ack, d_ack}, 0);
    void'(ack_q.pop_back());
    if_req = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);

    mdelay = 1;
    req_fetch(32'h100);
    wait_acks(1, 0);
    repeat (3) @(negedge clk);

    chk("ackq_left", ack_q.size(), 0);
    chk("busq_left", bus_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
